// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the parametrised FIFO.
// Optional almost-full/almost-empty outputs are enabled with PARAM_FIFO_ALMOST_EN.
package fifo_pkg;

    // Defaults match the fixed 8x9 FIFO this block replaces.
    localparam int DEFAULT_DATA_W = 9;
    localparam int DEFAULT_DEPTH  = 8;

    // Pointer width: one extra bit beyond the address distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // DEPTH must be a power of two so pointers can wrap modulo 2*DEPTH.
    function automatic bit is_pow2(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write, registered read with read-enable.
// The storage array is never reset; only the read register is.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    localparam int AW    = ptr_width(DEPTH) - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    // Storage write; contents survive reset and flush.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Next read data: load the addressed word on a read, otherwise hold.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // Read register; sees the pre-write word when reading and writing one address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with status and sticky error flags.
// Define PARAM_FIFO_ALMOST_EN to add AF_LVL/AE_LVL and almost_full/almost_empty.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
`ifdef PARAM_FIFO_ALMOST_EN
    parameter int AF_LVL = DEPTH - 1,
    parameter int AE_LVL = 1,
`endif
    localparam int AW    = ptr_width(DEPTH) - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow
`ifdef PARAM_FIFO_ALMOST_EN
    ,
    output logic              almost_full,
    output logic              almost_empty
`endif
);

    if (!is_pow2(DEPTH)) begin : g_depth_check
        $error("param_fifo: DEPTH must be a power of two and at least 2");
    end

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        dout_valid_q, dout_valid_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;
    logic        wr_acc;
    logic        rd_acc;

    // Status comes only from registered pointers, so no wr_en/rd_en path reaches it.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign count = wr_ptr_q - rd_ptr_q;

    // Accept logic and next state; flush overrides everything and raises no errors.
    always_comb begin
        wr_acc       = 1'b0;
        rd_acc       = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        dout_valid_d = 1'b0;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            wr_acc       = wr_en && (!full || rd_en);
            rd_acc       = rd_en && !empty;
            wr_ptr_d     = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
            rd_ptr_d     = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
            dout_valid_d = rd_acc;
            overflow_d   = overflow_q  || (wr_en && !wr_acc);
            underflow_d  = underflow_q || (rd_en && !rd_acc);
        end
    end

    // Pointer and flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign dout_valid = dout_valid_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

`ifdef PARAM_FIFO_ALMOST_EN
    logic [AW:0] count_d;
    logic        almost_full_q, almost_full_d;
    logic        almost_empty_q, almost_empty_d;

    // Thresholds use next occupancy so they change on the same edge as count.
    always_comb begin
        count_d        = wr_ptr_d - rd_ptr_d;
        almost_full_d  = (int'(count_d) >= AF_LVL);
        almost_empty_d = (int'(count_d) <= AE_LVL);
    end

    // Registered threshold flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
`endif

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data (din),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (dout)
    );

endmodule

// File: tb/tb_param_fifo.sv
// Directed testbench for param_fifo at DATA_W=9, DEPTH=8.
// Almost-flag checks are included when PARAM_FIFO_ALMOST_EN is defined.
module tb_param_fifo;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       wr_en;
    logic [8:0] din;
    logic       rd_en;
    logic [8:0] dout;
    logic       dout_valid;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;
`ifdef PARAM_FIFO_ALMOST_EN
    logic       almost_full;
    logic       almost_empty;
`endif

    int assert_cnt = 0;
    int fail_cnt   = 0;

    param_fifo #(
        .DATA_W (9),
        .DEPTH  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .wr_en      (wr_en),
        .din        (din),
        .rd_en      (rd_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
`ifdef PARAM_FIFO_ALMOST_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle of stimulus; returns 1 ns after the rising edge.
    task automatic cyc(input logic w, input logic [8:0] d, input logic r, input logic f);
        wr_en = w;
        din   = d;
        rd_en = r;
        flush = f;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        #12;
        assert_cnt++; if (empty !== 1'b1) begin fail_cnt++; $display("[TB] FAIL reset_empty got=%b exp=1", empty); end
        assert_cnt++; if (full !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_full got=%b exp=0", full); end
        assert_cnt++; if (count !== 4'd0) begin fail_cnt++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
        assert_cnt++; if (dout !== 9'h000) begin fail_cnt++; $display("[TB] FAIL reset_dout got=%h exp=000", dout); end
        assert_cnt++; if (dout_valid !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_valid got=%b exp=0", dout_valid); end
        assert_cnt++; if ({overflow, underflow} !== 2'b00) begin fail_cnt++; $display("[TB] FAIL reset_flags got=%b exp=00", {overflow, underflow}); end
`ifdef PARAM_FIFO_ALMOST_EN
        assert_cnt++; if ({almost_full, almost_empty} !== 2'b01) begin fail_cnt++; $display("[TB] FAIL reset_almost got=%b exp=01", {almost_full, almost_empty}); end
`endif
        rst = 1'b1;
        #1;
    endtask

    task automatic test_fill_overflow;
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 9'(9'h100 + i), 1'b0, 1'b0);
            assert_cnt++; if (count !== 4'(i)) begin fail_cnt++; $display("[TB] FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i); end
            assert_cnt++; if (full !== (i == 8)) begin fail_cnt++; $display("[TB] FAIL fill_full[%0d] got=%b exp=%b", i, full, (i == 8)); end
`ifdef PARAM_FIFO_ALMOST_EN
            assert_cnt++; if (almost_full !== (i >= 7)) begin fail_cnt++; $display("[TB] FAIL fill_af[%0d] got=%b exp=%b", i, almost_full, (i >= 7)); end
            assert_cnt++; if (almost_empty !== (i <= 1)) begin fail_cnt++; $display("[TB] FAIL fill_ae[%0d] got=%b exp=%b", i, almost_empty, (i <= 1)); end
`endif
        end
        assert_cnt++; if (overflow !== 1'b0) begin fail_cnt++; $display("[TB] FAIL fill_no_ovf got=%b exp=0", overflow); end
        cyc(1'b1, 9'h109, 1'b0, 1'b0);
        assert_cnt++; if (overflow !== 1'b1) begin fail_cnt++; $display("[TB] FAIL ovf_set got=%b exp=1", overflow); end
        assert_cnt++; if (count !== 4'd8) begin fail_cnt++; $display("[TB] FAIL ovf_count got=%0d exp=8", count); end
        assert_cnt++; if (dout_valid !== 1'b0) begin fail_cnt++; $display("[TB] FAIL ovf_valid got=%b exp=0", dout_valid); end
    endtask

    task automatic test_drain_underflow;
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 9'h000, 1'b1, 1'b0);
            assert_cnt++; if (dout !== 9'(9'h100 + i)) begin fail_cnt++; $display("[TB] FAIL drain_dout[%0d] got=%h exp=%h", i, dout, 9'(9'h100 + i)); end
            assert_cnt++; if (dout_valid !== 1'b1) begin fail_cnt++; $display("[TB] FAIL drain_valid[%0d] got=%b exp=1", i, dout_valid); end
        end
        assert_cnt++; if (empty !== 1'b1) begin fail_cnt++; $display("[TB] FAIL drain_empty got=%b exp=1", empty); end
        assert_cnt++; if (underflow !== 1'b0) begin fail_cnt++; $display("[TB] FAIL drain_no_udf got=%b exp=0", underflow); end
        cyc(1'b0, 9'h000, 1'b1, 1'b0);
        assert_cnt++; if (underflow !== 1'b1) begin fail_cnt++; $display("[TB] FAIL udf_set got=%b exp=1", underflow); end
        assert_cnt++; if (dout !== 9'h108) begin fail_cnt++; $display("[TB] FAIL udf_dout_hold got=%h exp=108", dout); end
        assert_cnt++; if (dout_valid !== 1'b0) begin fail_cnt++; $display("[TB] FAIL udf_valid got=%b exp=0", dout_valid); end
        assert_cnt++; if (count !== 4'd0) begin fail_cnt++; $display("[TB] FAIL udf_count got=%0d exp=0", count); end
    endtask

    task automatic test_full_rw;
        cyc(1'b0, 9'h000, 1'b0, 1'b1);
        assert_cnt++; if ({overflow, underflow} !== 2'b00) begin fail_cnt++; $display("[TB] FAIL flush_flags got=%b exp=00", {overflow, underflow}); end
        for (int i = 1; i <= 8; i++) cyc(1'b1, 9'(9'h100 + i), 1'b0, 1'b0);
        cyc(1'b1, 9'h1AA, 1'b1, 1'b0);
        assert_cnt++; if (dout !== 9'h101) begin fail_cnt++; $display("[TB] FAIL fullrw_dout got=%h exp=101", dout); end
        assert_cnt++; if (dout_valid !== 1'b1) begin fail_cnt++; $display("[TB] FAIL fullrw_valid got=%b exp=1", dout_valid); end
        assert_cnt++; if (count !== 4'd8) begin fail_cnt++; $display("[TB] FAIL fullrw_count got=%0d exp=8", count); end
        assert_cnt++; if (full !== 1'b1) begin fail_cnt++; $display("[TB] FAIL fullrw_full got=%b exp=1", full); end
        assert_cnt++; if (overflow !== 1'b0) begin fail_cnt++; $display("[TB] FAIL fullrw_ovf got=%b exp=0", overflow); end
        for (int i = 2; i <= 8; i++) begin
            cyc(1'b0, 9'h000, 1'b1, 1'b0);
            assert_cnt++; if (dout !== 9'(9'h100 + i)) begin fail_cnt++; $display("[TB] FAIL fullrw_drain[%0d] got=%h exp=%h", i, dout, 9'(9'h100 + i)); end
        end
        cyc(1'b0, 9'h000, 1'b1, 1'b0);
        assert_cnt++; if (dout !== 9'h1AA) begin fail_cnt++; $display("[TB] FAIL fullrw_last got=%h exp=1aa", dout); end
        assert_cnt++; if (empty !== 1'b1) begin fail_cnt++; $display("[TB] FAIL fullrw_empty got=%b exp=1", empty); end
    endtask

    task automatic test_empty_rw;
        cyc(1'b1, 9'h055, 1'b1, 1'b0);
        assert_cnt++; if (count !== 4'd1) begin fail_cnt++; $display("[TB] FAIL emptyrw_count got=%0d exp=1", count); end
        assert_cnt++; if (underflow !== 1'b1) begin fail_cnt++; $display("[TB] FAIL emptyrw_udf got=%b exp=1", underflow); end
        assert_cnt++; if (dout_valid !== 1'b0) begin fail_cnt++; $display("[TB] FAIL emptyrw_valid got=%b exp=0", dout_valid); end
        assert_cnt++; if (dout !== 9'h1AA) begin fail_cnt++; $display("[TB] FAIL emptyrw_dout got=%h exp=1aa", dout); end
        cyc(1'b0, 9'h000, 1'b1, 1'b0);
        assert_cnt++; if (dout !== 9'h055) begin fail_cnt++; $display("[TB] FAIL emptyrw_read got=%h exp=055", dout); end
        assert_cnt++; if (dout_valid !== 1'b1) begin fail_cnt++; $display("[TB] FAIL emptyrw_rvalid got=%b exp=1", dout_valid); end
    endtask

    task automatic test_flush_wrap;
        for (int i = 1; i <= 3; i++) cyc(1'b1, 9'(9'h010 + i), 1'b0, 1'b0);
        assert_cnt++; if (count !== 4'd3) begin fail_cnt++; $display("[TB] FAIL preflush_count got=%0d exp=3", count); end
        cyc(1'b1, 9'h0FF, 1'b0, 1'b1);
        assert_cnt++; if (count !== 4'd0) begin fail_cnt++; $display("[TB] FAIL flush_count got=%0d exp=0", count); end
        assert_cnt++; if (empty !== 1'b1) begin fail_cnt++; $display("[TB] FAIL flush_empty got=%b exp=1", empty); end
        assert_cnt++; if ({overflow, underflow} !== 2'b00) begin fail_cnt++; $display("[TB] FAIL flush_clear got=%b exp=00", {overflow, underflow}); end
        assert_cnt++; if (dout !== 9'h055) begin fail_cnt++; $display("[TB] FAIL flush_dout got=%h exp=055", dout); end
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 9'(9'h0C0 + i), 1'b0, 1'b0);
            cyc(1'b0, 9'h000, 1'b1, 1'b0);
            assert_cnt++; if (dout !== 9'(9'h0C0 + i)) begin fail_cnt++; $display("[TB] FAIL wrap_dout[%0d] got=%h exp=%h", i, dout, 9'(9'h0C0 + i)); end
            assert_cnt++; if (dout_valid !== 1'b1) begin fail_cnt++; $display("[TB] FAIL wrap_valid[%0d] got=%b exp=1", i, dout_valid); end
        end
        assert_cnt++; if (empty !== 1'b1) begin fail_cnt++; $display("[TB] FAIL wrap_empty got=%b exp=1", empty); end
    endtask

    task automatic test_async_reset;
        for (int i = 1; i <= 6; i++) cyc(1'b1, 9'(9'h060 + i), 1'b0, 1'b0);
        cyc(1'b0, 9'h000, 1'b1, 1'b0);
        assert_cnt++; if (count !== 4'd5) begin fail_cnt++; $display("[TB] FAIL prerst_count got=%0d exp=5", count); end
        assert_cnt++; if (dout !== 9'h061) begin fail_cnt++; $display("[TB] FAIL prerst_dout got=%h exp=061", dout); end
        #3;
        rst = 1'b0;
        #1;
        assert_cnt++; if (count !== 4'd0) begin fail_cnt++; $display("[TB] FAIL arst_count got=%0d exp=0", count); end
        assert_cnt++; if ({empty, full} !== 2'b10) begin fail_cnt++; $display("[TB] FAIL arst_empty_full got=%b exp=10", {empty, full}); end
        assert_cnt++; if (dout !== 9'h000) begin fail_cnt++; $display("[TB] FAIL arst_dout got=%h exp=000", dout); end
        assert_cnt++; if (dout_valid !== 1'b0) begin fail_cnt++; $display("[TB] FAIL arst_valid got=%b exp=0", dout_valid); end
        #2;
        rst = 1'b1;
        cyc(1'b0, 9'h000, 1'b1, 1'b0);
        assert_cnt++; if (underflow !== 1'b1) begin fail_cnt++; $display("[TB] FAIL postrst_udf got=%b exp=1", underflow); end
        assert_cnt++; if (dout_valid !== 1'b0) begin fail_cnt++; $display("[TB] FAIL postrst_valid got=%b exp=0", dout_valid); end
        assert_cnt++; if (dout !== 9'h000) begin fail_cnt++; $display("[TB] FAIL postrst_dout got=%h exp=000", dout); end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_full_rw();
        test_empty_rw();
        test_flush_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
- Synchronous single-clock FIFO; parametrised successor to the fixed 8x9 FIFO.
- Width and depth are generic; full/empty/count status and sticky error flags are added.
- Read/write handshakes are internal, so callers no longer step pointers by hand.
- Sits between producer/consumer datapaths in the course designs; drop-in buffer for any stream width.

Parameters:
- DATA_W, 9, data word width in bits (>=1).
- DEPTH, 8, number of entries; power of two, >=2.
- AW, $clog2(DEPTH), derived address width; not overridden by users.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (rst=0 resets).
- flush  in  1  synchronous clear of pointers, count and error flags.
- wr_en  in  1  write request.
- din  in  DATA_W  write data.
- rd_en  in  1  read request.
- dout  out  DATA_W  read data, registered.
- dout_valid  out  1  one-cycle pulse: dout carries the word from the previous cycle's accepted read.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- count  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Pointers: wr_ptr and rd_ptr are each AW+1 bits, wrapping modulo 2*DEPTH.
  - Memory index is the low AW bits.
  - full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
  - full, empty and count are registered/derived from registered pointers only; no combinational path from wr_en/rd_en.
- Write acceptance: wr_acc = wr_en & (~full | rd_en).
  - Write when full is accepted only together with a read.
  - On accept: mem[wr_ptr] <= din; wr_ptr increments.
- Read acceptance: rd_acc = rd_en & ~empty.
  - Read when empty is rejected even if wr_en is high; no fall-through.
  - On accept: dout <= mem[rd_ptr]; rd_ptr increments; dout_valid=1 in the next cycle.
  - Read latency is 1 cycle.
- Hold: dout holds its last value when no read is accepted. No tri-state outputs.
- Count update: +1 for write-only, -1 for read-only, unchanged for both or neither.
- Errors:
  - wr_en & ~wr_acc sets overflow.
  - rd_en & ~rd_acc sets underflow.
  - Both flags stay set until flush or reset.
- flush: highest synchronous priority.
  - Same cycle: pointers=0, count=0, overflow/underflow=0, dout_valid=0.
  - wr_en/rd_en are ignored and do not set error flags.
  - dout is unchanged; memory contents are not cleared.
- Reset (async, rst=0):
  - Pointers=0, count=0, dout=0, dout_valid=0, overflow=0, underflow=0, so empty=1 and full=0.
  - Memory is not reset.
  - Reset mid-operation discards all contents; the first cycle after release behaves as empty.
- Wrap-around: pointers wrap silently; DEPTH consecutive writes then DEPTH reads return the data in order.

Optional Feature:
- Macro: PARAM_FIFO_ALMOST_EN.
- Defined:
  - Adds parameters AF_LVL (default DEPTH-1) and AE_LVL (default 1).
  - Adds outputs almost_full (count>=AF_LVL) and almost_empty (count<=AE_LVL), both registered, updated on the same edge as count.
  - Reset values: almost_full=0, almost_empty=1.
- Undefined: the parameters and ports are absent; all other behaviour is identical.

Decomposition:
- Package fifo_pkg: localparam helper function for pointer width, the DEPTH power-of-two check, and the default DATA_W/DEPTH constants.
- Sub-module fifo_mem: simple dual-port RAM, synchronous write, registered read with read-enable.
  - param_fifo instantiates one fifo_mem and keeps pointers, flags and control.

Test Plan:
1. Reset, then 8 writes 0x101..0x108 with no reads (DEPTH=8) -> full=1 after the 8th edge, count=8; 9th write sets overflow=1, count stays 8.
2. From full, 8 reads -> dout=0x101..0x108 in order, each one cycle after its rd_en; empty=1 at the end; 9th read sets underflow=1, dout stays 0x108, no dout_valid.
3. Full, simultaneous wr_en+rd_en with din=0x1AA -> read of the oldest word accepted, write accepted, count stays 8, overflow stays 0; 0x1AA emerges after 7 further reads.
4. Empty, simultaneous wr_en+rd_en with din=0x055 -> write accepted, read rejected, underflow=1, count=1; the next read returns 0x055.
5. 3 writes, then flush asserted with wr_en=1 -> count=0, empty=1, flags cleared, wr_en ignored; 20 write/read pairs across the pointer wrap -> data preserved in order.
6. rst driven low mid-stream, asynchronously between clock edges, with count=5 -> outputs go to reset values immediately; after release, a read gives underflow and no dout_valid.
